xillybus_host_emu: RTL
======================

# xillybus_host_emu

Host-side endpoint for the Xillybus 32-bit stream pair in simulation and on-chip self-test: plays the role the Xillybus core and host software play toward the accelerator wrapper. Takes a batch of 16-bit elements from a local source stream, packs them two per 32-bit word into the write file, then drains the read file and unpacks the results to a local sink stream. It sequences the file `open` signals and `quiesce` around each batch so the accelerator FSM and its FIFOs start from a clean state.

## Interface
- `ELEM_COUNT`, 256: 16-bit elements per batch. Must be even and ≥2; elaboration error otherwise.
- `CLOSE_CYCLES`, 4: cycles both files stay closed after a batch.
- `TIMEOUT`, 4096: maximum idle cycles in READ before abort.

Ports:
- `bus_clk` in 1: clock.
- `bus_rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin a batch; sampled only in IDLE.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse at the end of CLOSE.
- `timeout` out 1: sticky abort flag; cleared on accepted `start`.
- `src_data` in 16, `src_valid` in 1, `src_ready` out 1: element source stream.
- `snk_data` out 16, `snk_valid` out 1, `snk_ready` in 1: result sink stream.
- `quiesce` out 1.
- `user_w_write_32_open` out 1, `user_w_write_32_wren` out 1, `user_w_write_32_data` out 32, `user_w_write_32_full` in 1.
- `user_r_read_32_open` out 1, `user_r_read_32_rden` out 1, `user_r_read_32_data` in 32, `user_r_read_32_empty` in 1.

## Operation
- One-hot FSM: IDLE → OPEN → WRITE → READ → CLOSE → IDLE.
- IDLE: both opens low, `quiesce` low. `start` moves to OPEN, clears `timeout`, and zeroes all counters.
- OPEN: lasts 1 cycle. Both opens rise on entry and stay high through WRITE and READ.
- WRITE packing: element 2k goes to `[15:0]` and element 2k+1 to `[31:16]`.
  - `src_ready` = WRITE && !word_pend.
  - The second element of a pair loads the word register and sets word_pend.
  - `wren` = word_pend && !full. word_pend clears on wren.
  - After ELEM_COUNT/2 writes, go to READ.
- READ:
  - `rden` = READ && !empty && !rd_pend && !hold_valid && words_left≠0.
  - Data from the read FIFO is captured the cycle after rden (standard FIFO, not FWFT) into the hold register, and hold_valid is set.
  - `snk_data` presents the low half, then the high half. hold_valid clears on the handshake of the high half.
  - After the final word and final element handshake, go to CLOSE.
- Timeout: an idle counter increments each READ cycle without rden and resets on rden. When it reaches TIMEOUT: set `timeout`, discard any held data (`snk_valid` low), go to CLOSE.
- CLOSE: both opens low, `quiesce` high, for CLOSE_CYCLES cycles. Then `done` pulses and the FSM returns to IDLE.
- Width rules: counters are $clog2(ELEM_COUNT/2+1) bits, with no wrap-around inside a batch. The idle counter is $clog2(TIMEOUT+1) bits and saturates.

## Timing
- Reset values (asynchronous, immediate on `bus_rst_n` low): state IDLE; `busy`, `done`, `timeout`, `src_ready`, `snk_valid`, `wren`, `rden`, `quiesce`, both opens all 0; `snk_data` and `user_w_write_32_data` 0.
- Reset mid-batch: abandons the batch with no `done`. Both opens drop asynchronously, which resets the peer FIFOs.
- `start`→opens high: 1 cycle. Opens high→first `src_ready`: 1 cycle.
- `full` high: `wren` stays low, and write data and word_pend are held. No data is lost.
- `snk_ready` low: `snk_data` is stable and no further rden is issued.
- `start` while busy: ignored.
- `done` and the return to IDLE occur in the same cycle.

## Structure
- `xillybus_host_pkg`: state encodings (5-bit one-hot) and default ELEM_COUNT, CLOSE_CYCLES, TIMEOUT constants. Shared with the accelerator wrapper benches.
- Sub-module `xillybus_word_unpacker`: the hold register, half-select and sink handshake. The top contains the FSM, the packer and the counters.

## Test plan
- Loopback FIFO model, ELEM_COUNT=4, src 0x0001..0x0004:
  - writes are 0x00020001 then 0x00040003;
  - snk outputs 0x0001, 0x0002, 0x0003, 0x0004;
  - opens low and `quiesce` high for 4 cycles, then a single `done` pulse.
- `full` held high 3 cycles with word 0x00020001 pending → `wren` low for those 3 cycles, data held, exactly one write on the 4th cycle.
- `snk_ready` low 5 cycles mid-word → `snk_data` constant, `rden` stays 0, and no element is dropped or duplicated.
- `empty` stuck high, TIMEOUT=16 → `timeout`=1 after 16 idle READ cycles, then CLOSE then `done`. The next `start` clears `timeout`.
- `bus_rst_n` low mid-WRITE → all outputs take reset values in the same cycle. A fresh batch after release completes correctly.
- `start` pulsed during READ → no effect. The batch completes with exactly ELEM_COUNT sink handshakes.

Source files
------------

// File: rtl/xillybus_host_pkg.sv
// Shared definitions for the Xillybus host-side emulator and the accelerator wrapper benches.
// Latency: n/a (types, constants and a packing helper only).
// Backpressure: n/a.
package xillybus_host_pkg;

  // Batch sequencer states, one-hot so each state is a single flop.
  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_OPEN  = 5'b00010,
    S_WRITE = 5'b00100,
    S_READ  = 5'b01000,
    S_CLOSE = 5'b10000
  } state_t;

  localparam int DEF_ELEM_COUNT   = 256;
  localparam int DEF_CLOSE_CYCLES = 4;
  localparam int DEF_TIMEOUT      = 4096;

  // Even element lands in the low half, odd element in the high half.
  function automatic logic [31:0] pack_pair(input logic [15:0] lo, input logic [15:0] hi);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/xillybus_word_unpacker.sv
// Holds one 32-bit read word and presents it as two 16-bit sink elements, low half first.
// Latency: element visible the cycle after load; one element per cycle while snk_ready is high.
// Backpressure: snk_ready low freezes snk_data; the word is released only on the high-half handshake.
module xillybus_word_unpacker (
  input  logic        bus_clk,
  input  logic        bus_rst_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        flush,
  output logic [15:0] snk_data,
  output logic        snk_valid,
  input  logic        snk_ready,
  output logic        last_hs
);

  logic [31:0] hold;
  logic        hold_valid;
  logic        hi_half;

  assign snk_valid = hold_valid;
  assign snk_data  = hi_half ? hold[31:16] : hold[15:0];
  // Handshake of the high half retires the whole word.
  assign last_hs   = hold_valid && hi_half && snk_ready;

  // Capture a fetched word, then step low half -> high half on each sink handshake; flush drops it.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      hi_half    <= 1'b0;
    end else if (flush) begin
      hold_valid <= 1'b0;
      hi_half    <= 1'b0;
    end else if (load) begin
      hold       <= load_data;
      hold_valid <= 1'b1;
      hi_half    <= 1'b0;
    end else if (hold_valid && snk_ready) begin
      if (hi_half) begin
        hold_valid <= 1'b0;
        hi_half    <= 1'b0;
      end else begin
        hi_half    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/xillybus_host_emu.sv
// Host-side Xillybus 32-bit stream-pair emulator: packs a batch of source elements into the write file, unpacks the read file to the sink.
// Latency: start->opens high 1 cycle, opens->src_ready 1 cycle; read data captured 1 cycle after rden.
// Backpressure: full stalls wren with the word held; snk_ready low freezes snk_data and blocks rden; READ aborts after TIMEOUT idle cycles.
module xillybus_host_emu
  import xillybus_host_pkg::*;
#(
  parameter int ELEM_COUNT   = DEF_ELEM_COUNT,
  parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic        bus_clk,
  input  logic        bus_rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  input  logic [15:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic [15:0] snk_data,
  output logic        snk_valid,
  input  logic        snk_ready,
  output logic        quiesce,
  output logic        user_w_write_32_open,
  output logic        user_w_write_32_wren,
  output logic [31:0] user_w_write_32_data,
  input  logic        user_w_write_32_full,
  output logic        user_r_read_32_open,
  output logic        user_r_read_32_rden,
  input  logic [31:0] user_r_read_32_data,
  input  logic        user_r_read_32_empty
);

  localparam int WORDS = ELEM_COUNT / 2;
  localparam int CW    = $clog2(WORDS + 1);
  localparam int IW    = $clog2(TIMEOUT + 1);
  localparam int KW    = (CLOSE_CYCLES > 1) ? $clog2(CLOSE_CYCLES) : 1;

  localparam logic [CW-1:0] WORDS_C    = CW'(WORDS);
  localparam logic [CW-1:0] WORDS_M1   = CW'(WORDS - 1);
  localparam logic [IW-1:0] TIMEOUT_C  = IW'(TIMEOUT);
  localparam logic [KW-1:0] CLOSE_LAST = KW'(CLOSE_CYCLES - 1);

  generate
    if ((ELEM_COUNT < 2) || ((ELEM_COUNT % 2) != 0)) begin : g_bad_elem_count
      $error("xillybus_host_emu: ELEM_COUNT must be even and >= 2");
    end
    if (CLOSE_CYCLES < 1) begin : g_bad_close_cycles
      $error("xillybus_host_emu: CLOSE_CYCLES must be >= 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("xillybus_host_emu: TIMEOUT must be >= 1");
    end
  endgenerate

  state_t        state;
  logic          files_open;
  logic [KW-1:0] close_cnt;

  // Packer state
  logic          word_pend;
  logic          elem_odd;
  logic [15:0]   lo_elem;
  logic [31:0]   wr_word;
  logic [CW-1:0] wr_words;

  // Read-side state
  logic          rd_pend;
  logic [CW-1:0] rd_words;
  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] idle_inc;

  logic          start_acc;
  logic          in_write;
  logic          in_read;
  logic          src_fire;
  logic          wr_last;
  logic          rd_last;
  logic          idle_hit;
  logic          last_hs;

  assign in_write  = (state == S_WRITE);
  assign in_read   = (state == S_READ);
  assign start_acc = (state == S_IDLE) && start;

  assign user_w_write_32_open = files_open;
  assign user_r_read_32_open  = files_open;
  assign user_w_write_32_data = wr_word;

  // One pending word at a time: the source is throttled while a packed word waits for the write file.
  assign src_ready            = in_write && !word_pend;
  assign src_fire             = src_ready && src_valid;
  assign user_w_write_32_wren = word_pend && !user_w_write_32_full;
  assign wr_last              = user_w_write_32_wren && (wr_words == WORDS_M1);

  // Standard (non-FWFT) read FIFO: at most one read in flight, and only into an empty hold register.
  assign user_r_read_32_rden = in_read && !user_r_read_32_empty && !rd_pend && !snk_valid
                               && (rd_words != WORDS_C);

  assign idle_inc = (idle_cnt == {IW{1'b1}}) ? idle_cnt : idle_cnt + IW'(1);
  assign idle_hit = in_read && !user_r_read_32_rden && (idle_inc == TIMEOUT_C);
  assign rd_last  = in_read && last_hs && (rd_words == WORDS_C);

  // Batch sequencer: opens, quiesce, busy, done and timeout are all registered here.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      quiesce    <= 1'b0;
      files_open <= 1'b0;
      close_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_OPEN;
            busy       <= 1'b1;
            timeout    <= 1'b0;
            files_open <= 1'b1;
            close_cnt  <= '0;
          end
        end
        S_OPEN: begin
          state <= S_WRITE;
        end
        S_WRITE: begin
          if (wr_last) begin
            state <= S_READ;
          end
        end
        S_READ: begin
          // An expired idle count wins over a coincident final handshake.
          if (idle_hit || rd_last) begin
            state      <= S_CLOSE;
            files_open <= 1'b0;
            quiesce    <= 1'b1;
            close_cnt  <= '0;
            if (idle_hit) begin
              timeout <= 1'b1;
            end
          end
        end
        S_CLOSE: begin
          if (close_cnt == CLOSE_LAST) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            quiesce <= 1'b0;
          end else begin
            close_cnt <= close_cnt + KW'(1);
          end
        end
        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          quiesce    <= 1'b0;
          files_open <= 1'b0;
        end
      endcase
    end
  end

  // Packer: pair consecutive source elements into one write word and hold it until the write file takes it.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      word_pend <= 1'b0;
      elem_odd  <= 1'b0;
      lo_elem   <= '0;
      wr_word   <= '0;
      wr_words  <= '0;
    end else if (start_acc) begin
      word_pend <= 1'b0;
      elem_odd  <= 1'b0;
      wr_words  <= '0;
    end else begin
      if (src_fire) begin
        if (elem_odd) begin
          wr_word   <= pack_pair(lo_elem, src_data);
          word_pend <= 1'b1;
        end else begin
          lo_elem <= src_data;
        end
        elem_odd <= !elem_odd;
      end
      if (user_w_write_32_wren) begin
        word_pend <= 1'b0;
        wr_words  <= wr_words + CW'(1);
      end
    end
  end

  // Read side: flag the in-flight read, count fetched words, count READ cycles without a read.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      rd_pend  <= 1'b0;
      rd_words <= '0;
      idle_cnt <= '0;
    end else if (start_acc) begin
      rd_pend  <= 1'b0;
      rd_words <= '0;
      idle_cnt <= '0;
    end else begin
      rd_pend <= user_r_read_32_rden;
      if (user_r_read_32_rden) begin
        rd_words <= rd_words + CW'(1);
      end
      if (in_read) begin
        idle_cnt <= user_r_read_32_rden ? '0 : idle_inc;
      end
    end
  end

  xillybus_word_unpacker u_unpacker (
    .bus_clk   (bus_clk),
    .bus_rst_n (bus_rst_n),
    .load      (rd_pend),
    .load_data (user_r_read_32_data),
    .flush     (idle_hit),
    .snk_data  (snk_data),
    .snk_valid (snk_valid),
    .snk_ready (snk_ready),
    .last_hs   (last_hs)
  );

endmodule
